int_ctrl: RTL and testbench

- Interrupt controller directly upstream of the fetch stage.
- Collects edge-triggered requests from up to N_SRC peripheral sources, latches them as pending, applies a software-written mask, and selects one by fixed priority.
- Drives the single-wire request `ipu_int` into fetch and waits for fetch's `int_ack`.
- Holds the serviced source ID stable until the handler's return instruction (opcode 4'b0011) is decoded and reported on `int_ret`.

---
 rtl/int_ctrl.sv | 156 +++++++++++++++
 tb/tb_int_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//   Interrupt controller sitting directly upstream of the fetch stage.
//   Raw interrupt lines are synchronized and edge-detected. Each edge is latched
//   as pending. Pending sources enabled by the software mask are arbitrated by
//   fixed priority, where the lowest index wins. The winner is presented to
//   fetch on ipu_int until fetch acknowledges it. Its ID is then held until the
//   handler's return instruction is reported on int_ret.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-high reset
//   src_in      raw interrupt lines; a rising edge is a request
//   mask_wr     write strobe for the mask register
//   mask_data   new mask value; a 1 enables the source
//   int_ack     from fetch: registered acknowledge of the taken request
//   int_ret     one-cycle pulse: return-from-interrupt was decoded
//   ipu_int     registered interrupt request to fetch
//   int_id      ID of the granted or in-service source
//   pending     pending register
//   overrun     sticky: an edge arrived while that bit was already pending
//   in_service  high from grant until return
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int N_SRC       = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_data,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             ipu_int,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun,
    output logic             in_service
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]       state;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] sync_q;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] clear;
    logic [N_SRC-1:0] eligible;
    logic [ID_W-1:0]  win_idx;

    // ---------------------------------------------------------------- synchronizer
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_q = src_in;
        end else begin : g_sync
            logic [N_SRC-1:0] stage [SYNC_STAGES];

            // NOTE: the synchronizer is a chain of flops rather than a RAM, so
            // every stage is cleared by reset. Otherwise a stale 1 could fake an
            // edge when reset is released.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= src_in;
                    for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
                end
            end

            assign sync_q = stage[SYNC_STAGES-1];
        end
    endgenerate

    assign edge_det = sync_q & ~prev_q;
    assign eligible = pending & mask;

    // The granted source is consumed on the acknowledge edge only.
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        clear   = '0;
        win_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clear[i] = (state == ST_REQ) && int_ack && (int_id == ID_W'(i));
        end
        // Scan from the top down so that the lowest eligible index is written last.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = ID_W'(i);
        end
    end

    // ------------------------------------------------------- pending / overrun / mask
    // NOTE: sequential state uses non-blocking assignments only. Every flop then
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= '0;
            pending <= '0;
            overrun <= '0;
            mask    <= '1;
        end else begin
            prev_q  <= sync_q;
            // If a new edge and the acknowledge clear land together, the edge
            // wins, so that request is not lost.
            pending <= (pending & ~clear) | edge_det;
            overrun <= overrun | (edge_det & pending & ~clear);
            if (mask_wr) mask <= mask_data;
        end
    end

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ipu_int    <= 1'b0;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        state      <= ST_REQ;
                        int_id     <= win_idx;
                        ipu_int    <= 1'b1;
                        in_service <= 1'b1;
                    end
                end
                // No withdrawal and no preemption here: fetch may already have
                // redirected the PC, so int_id stays frozen until the return.
                ST_REQ: begin
                    if (int_ack) begin
                        state   <= ST_SERVICE;
                        ipu_int <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (int_ret) begin
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ipu_int    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
//   Directed testbench for int_ctrl with N_SRC=4, ID_W=2 and SYNC_STAGES=2.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at the
//   same point.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] src_in;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       int_ack;
    logic       int_ret;
    logic       ipu_int;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    int_ctrl #(.N_SRC(4), .ID_W(2), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_in     (src_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .ipu_int    (ipu_int),
        .int_id     (int_id),
        .pending    (pending),
        .overrun    (overrun),
        .in_service (in_service)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for ipu_int. The timeout counts as a failed comparison.
    task automatic wait_ipu(input string name);
        int n = 0;
        while (!ipu_int && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (ipu_int !== 1'b1) begin
            errors++;
            $display("FAIL %s: ipu_int=%b after %0d cycles, expected 1", name, ipu_int, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; src_in = '0; mask_wr = 1'b0; mask_data = '0;
        int_ack = 1'b0; int_ret = 1'b0;
        step(); step();
        checks++;
        if ({ipu_int, in_service, int_id, pending, overrun} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: ipu=%b insvc=%b id=%0d pend=%b ovr=%b, expected all 0",
                     ipu_int, in_service, int_id, pending, overrun);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        src_in[2] = 1'b1;
        step(); step();
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL single_pend_e2: pending=%b expected 0000", pending); end
        step();
        checks++;
        if (pending !== 4'b0100 || ipu_int !== 1'b0) begin
            errors++; $display("FAIL single_pend_e3: pending=%b ipu=%b expected 0100/0", pending, ipu_int);
        end
        step();
        checks++;
        if (ipu_int !== 1'b1 || int_id !== 2'd2 || in_service !== 1'b1) begin
            errors++; $display("FAIL single_grant: ipu=%b id=%0d insvc=%b expected 1/2/1", ipu_int, int_id, in_service);
        end
        step();
        checks++;
        if (ipu_int !== 1'b1) begin errors++; $display("FAIL single_ipu_cyc2: ipu=%b expected 1", ipu_int); end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b1) begin
            errors++; $display("FAIL single_ack: ipu=%b pend=%b insvc=%b expected 0/0000/1", ipu_int, pending, in_service);
        end
        src_in[2] = 1'b0;
        repeat (3) step();
        checks++;
        if (in_service !== 1'b1 || int_id !== 2'd2) begin
            errors++; $display("FAIL single_hold: insvc=%b id=%0d expected 1/2", in_service, int_id);
        end
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        checks++;
        if (in_service !== 1'b0 || ipu_int !== 1'b0) begin
            errors++; $display("FAIL single_ret: insvc=%b ipu=%b expected 0/0", in_service, ipu_int);
        end
    endtask

    task automatic test_priority();
        src_in = 4'b1010;
        repeat (3) step();
        checks++;
        if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pend: pending=%b expected 1010", pending); end
        step();
        checks++;
        if (ipu_int !== 1'b1 || int_id !== 2'd1) begin
            errors++; $display("FAIL prio_first: ipu=%b id=%0d expected 1/1", ipu_int, int_id);
        end
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b1000) begin
            errors++; $display("FAIL prio_ack: ipu=%b pend=%b expected 0/1000", ipu_int, pending);
        end
        src_in = '0;
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        checks++;
        if (in_service !== 1'b0 || ipu_int !== 1'b0) begin
            errors++; $display("FAIL prio_idle_gap: insvc=%b ipu=%b expected 0/0", in_service, ipu_int);
        end
        step();
        checks++;
        if (ipu_int !== 1'b1 || int_id !== 2'd3) begin
            errors++; $display("FAIL prio_second: ipu=%b id=%0d expected 1/3", ipu_int, int_id);
        end
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL prio_empty: pending=%b expected 0000", pending); end
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        step();
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_data = 4'b1110;
        step();
        mask_wr = 1'b0;
        src_in[0] = 1'b1;
        repeat (3) step();
        checks++;
        if (pending !== 4'b0001 || ipu_int !== 1'b0) begin
            errors++; $display("FAIL mask_latch: pend=%b ipu=%b expected 0001/0", pending, ipu_int);
        end
        repeat (3) step();
        checks++;
        if (ipu_int !== 1'b0) begin errors++; $display("FAIL mask_block: ipu=%b expected 0", ipu_int); end
        mask_wr = 1'b1; mask_data = 4'b1111;
        step();
        mask_wr = 1'b0;
        checks++;
        if (ipu_int !== 1'b0) begin errors++; $display("FAIL mask_wr_edge: ipu=%b expected 0", ipu_int); end
        step();
        checks++;
        if (ipu_int !== 1'b1 || int_id !== 2'd0) begin
            errors++; $display("FAIL mask_grant: ipu=%b id=%0d expected 1/0", ipu_int, int_id);
        end
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        src_in = '0;
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_overrun();
        src_in[1] = 1'b1; step();
        src_in[1] = 1'b0; step();
        src_in[1] = 1'b1; step();
        checks++;
        if (pending !== 4'b0010) begin errors++; $display("FAIL ovr_pend: pending=%b expected 0010", pending); end
        src_in[1] = 1'b0; step();
        checks++;
        if (ipu_int !== 1'b1 || int_id !== 2'd1 || overrun !== 4'b0000) begin
            errors++; $display("FAIL ovr_grant: ipu=%b id=%0d ovr=%b expected 1/1/0000", ipu_int, int_id, overrun);
        end
        step();
        checks++;
        if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_sticky: overrun=%b expected 0010", overrun); end
        src_in[1] = 1'b1; step();
        src_in[1] = 1'b0; step();
        checks++;
        if (ipu_int !== 1'b1) begin errors++; $display("FAIL ovr_still_req: ipu=%b expected 1", ipu_int); end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0010 || in_service !== 1'b1 || overrun !== 4'b0010) begin
            errors++; $display("FAIL set_over_clear: ipu=%b pend=%b insvc=%b ovr=%b expected 0/0010/1/0010",
                               ipu_int, pending, in_service, overrun);
        end
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        step();
        checks++;
        if (ipu_int !== 1'b1 || int_id !== 2'd1) begin
            errors++; $display("FAIL ovr_reservice: ipu=%b id=%0d expected 1/1", ipu_int, int_id);
        end
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++;
        if (pending !== 4'b0000) begin errors++; $display("FAIL ovr_drain: pending=%b expected 0000", pending); end
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        step();
    endtask

    task automatic test_stall();
        src_in[2] = 1'b1;
        wait_ipu("stall_wait");
        src_in[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int_ret = (i == 4);
            step();
            checks++;
            if (ipu_int !== 1'b1 || int_id !== 2'd2 || in_service !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: ipu=%b id=%0d insvc=%b expected 1/2/1", i, ipu_int, int_id, in_service);
            end
        end
        int_ret = 1'b0;
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++;
        if (ipu_int !== 1'b0 || in_service !== 1'b1) begin
            errors++; $display("FAIL stall_ack: ipu=%b insvc=%b expected 0/1", ipu_int, in_service);
        end
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        checks++;
        if (in_service !== 1'b0) begin errors++; $display("FAIL stall_ret: insvc=%b expected 0", in_service); end
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        src_in = 4'b0101;
        wait_ipu("rstmid_wait");
        checks++;
        if (int_id !== 2'd0) begin errors++; $display("FAIL rstmid_id: id=%0d expected 0", int_id); end
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        src_in = '0;
        repeat (3) step();
        src_in[0] = 1'b1;
        repeat (3) step();
        src_in = '0;
        checks++;
        if (pending !== 4'b0101 || in_service !== 1'b1 || overrun !== 4'b0010) begin
            errors++; $display("FAIL rstmid_pre: pend=%b insvc=%b ovr=%b expected 0101/1/0010", pending, in_service, overrun);
        end
        mask_wr = 1'b1; mask_data = 4'b0000;
        step();
        mask_wr = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ipu_int, in_service, int_id, pending, overrun} !== 11'b0) begin
            errors++; $display("FAIL rstmid_async: ipu=%b insvc=%b id=%0d pend=%b ovr=%b expected all 0",
                               ipu_int, in_service, int_id, pending, overrun);
        end
        step();
        rst = 1'b0;
        step();
        src_in[3] = 1'b1;
        wait_ipu("rstmid_mask_restored");
        checks++;
        if (int_id !== 2'd3) begin errors++; $display("FAIL rstmid_regrant: id=%0d expected 3", int_id); end
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        src_in = '0;
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_overrun();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
